if_fetch_unit: RTL

- Instruction fetch stage; it is the producer side of the decode control path.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small queue and presents op/funct/instr fields to decode.
- Consumes the decoder's pc_sel redirect code (0 = seq, 1 = branch, 2 = j/jal, 3 = jr) to steer the PC and flush wrong-path fetches.

---
 rtl/if_pkg.sv | 44 ++++
 rtl/if_instr_fifo.sv | 86 ++++++++
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch stage and its decode-side
// controller: redirect codes, NOP encoding, queue entry layout and the
// redirect target computation.
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int INSTR_W = 32;

  // Redirect codes driven by the decoder on pc_sel.
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_J   = 2'd2;
  localparam logic [1:0] PC_SEL_JR  = 2'd3;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  // One queued fetch result: the instruction and the pc+4 of its address.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
  } if_entry_t;

  // Target PC for a redirect. The jr target always has its low two bits
  // cleared; misalignment reporting (if any) is done by the caller.
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  sel,
    input logic [31:0] pc4,
    input logic [15:0] imm,
    input logic [25:0] idx,
    input logic [31:0] jr
  );
    logic [31:0] t;
    case (sel)
      PC_SEL_BR: t = pc4 + {{14{imm[15]}}, imm, 2'b00};
      PC_SEL_J:  t = {pc4[31:28], idx, 2'b00};
      PC_SEL_JR: t = jr & 32'hFFFF_FFFC;
      default:   t = pc4;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_instr_fifo.sv
// -----------------------------------------------------------------------------
// if_instr_fifo
// DEPTH-entry synchronous FIFO of if_entry_t (instr + pc4, 64 bits) with a
// synchronous flush. DEPTH must be a power of two so the pointers wrap freely.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, data_i    write an entry (ignored during flush)
//   pop_i             remove the head entry (ignored during flush)
//   flush_i           discard all entries; wins over push/pop
//   data_o            head entry (stale when empty)
//   count_o           number of valid entries
//   empty_o           count_o == 0
// -----------------------------------------------------------------------------
module if_instr_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  if_entry_t              data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output if_entry_t              data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full;

  assign full    = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // The fetch credit rule must keep the queue from overflowing/underflowing.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(push_i && !pop_i && full));
      assert (!(pop_i && empty_o));
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage. Holds the PC, issues in-order word requests to
// instruction memory, queues returned words and presents them to decode.
// A nonzero pc_sel from decode redirects the PC and flushes wrong-path work.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; once raised, imem_req_valid/imem_addr hold until accepted, except
// that a redirect withdraws the request. imem_resp_valid is always accepted.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pc_sel                         redirect code (0 = none, 1 br, 2 j, 3 jr)
//   redir_pc4, br_imm, j_index,
//   jr_addr                        redirect target operands
//   imem_req_valid/ready, imem_addr       request channel
//   imem_resp_valid, imem_resp_data       in-order response channel
//   id_valid/ready, id_instr, id_pc4,
//   id_op, id_funct, id_is_nop            decode channel (head of queue)
//   if_misalign_err                only with IF_ALIGN_CHECK_EN: sticky jr
//                                  misalignment flag, halts fetch
//
// Build option: define IF_ALIGN_CHECK_EN to enable jr alignment checking.
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic [31:0]        redir_pc4,
  input  logic [15:0]        br_imm,
  input  logic [25:0]        j_index,
  input  logic [31:0]        jr_addr,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc4,
  output logic [5:0]         id_op,
  output logic [5:0]         id_funct,
  output logic               id_is_nop
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic               if_misalign_err
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  // Wrong-path words still owed by memory. Requests issued after a redirect
  // are not covered by credit from dropped ones, so repeated redirects can
  // stack up; the extra headroom covers that.
  localparam int DW = CW + 4;
  localparam logic [CW:0] QDEPTH_C = (CW + 1)'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  // Address of the oldest live in-flight request; in-flight requests are
  // always a contiguous sequential run starting here.
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [DW-1:0] drop_q, drop_d;

  logic          redirect;
  logic [31:0]   target;
  logic          credit_ok;
  logic          fetch_halt;
  logic          req_hs;
  logic          resp_live;
  logic          pop;
  logic [CW-1:0] q_count;
  logic          q_empty;
  if_entry_t     q_head;
  if_entry_t     q_in;

  assign redirect = (pc_sel != PC_SEL_SEQ);
  assign target   = redirect_target(pc_sel, redir_pc4, br_imm, j_index, jr_addr);

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d      = misalign_q | ((pc_sel == PC_SEL_JR) && (jr_addr[1:0] != 2'b00));
  assign fetch_halt      = misalign_q;
  assign if_misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign fetch_halt = 1'b0;
`endif

  assign credit_ok      = ({1'b0, infl_q} + {1'b0, q_count}) < QDEPTH_C;
  assign imem_req_valid = ~rst & ~redirect & credit_ok & ~fetch_halt;
  assign imem_addr      = pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;

  // Responses owed to dropped requests come back first (in-order memory).
  assign resp_live = imem_resp_valid & (drop_q == '0) & ~redirect;
  assign q_in      = '{instr: imem_resp_data, pc4: rpc_q + 32'd4};

  assign id_valid  = ~q_empty & ~redirect;
  assign pop       = id_valid & id_ready;
  assign id_instr  = q_empty ? NOP_WORD : q_head.instr;
  assign id_pc4    = q_empty ? 32'h0 : q_head.pc4;
  assign id_op     = id_instr[31:26];
  assign id_funct  = id_instr[5:0];
  // Qualified by occupancy so an empty stage does not advertise a NOP.
  assign id_is_nop = ~q_empty & (q_head.instr == NOP_WORD);

  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    infl_d = infl_q;
    drop_d = drop_q;
    if (redirect) begin
      pc_d   = target;
      rpc_d  = target;
      infl_d = '0;
      // Everything still outstanding becomes wrong-path; a response landing
      // this cycle is discarded here, so it is not owed any more.
      drop_d = drop_q + DW'(infl_q) - DW'(imem_resp_valid);
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      if (imem_resp_valid) begin
        if (drop_q != '0) drop_d = drop_q - 1'b1;
        else              rpc_d  = rpc_q + 32'd4;
      end
      infl_d = infl_q + CW'(req_hs) - CW'(resp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      infl_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
    end
  end

  if_instr_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (resp_live),
    .data_i  (q_in),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty)
  );

endmodule
